// File: rtl/string_fifo_host_if.sv
// Avalon-MM host bus between string_fifo_host (master) and a memory/FIFO agent (slave).
// Commands are accepted in a cycle where the strobe is high and waitrequest is low.
interface string_fifo_host_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/string_fifo_host.sv
// Copies up to 16 words from src_addr to an accelerator FIFO port: 3 cycles/word (RD, RD_LAT, WR), strobes held under waitrequest.
// Define STRING_HOST_DST_INC_EN to increment the write address per word (memory-to-memory copy).
module string_fifo_host #(
  parameter int NWORDS_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [NWORDS_W-1:0] num_words,
  output logic                busy,
  output logic                done,
  output logic [NWORDS_W-1:0] words_done,
  string_fifo_host_if.master  avm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_LAT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [NWORDS_W-1:0] MAX_WORDS = NWORDS_W'(16);
  localparam int OFF_PAD = 30 - NWORDS_W;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [NWORDS_W-1:0] nwords_q;
  logic [31:0]         data_q;
  logic [NWORDS_W-1:0] nwords_clamped;
  logic [NWORDS_W-1:0] words_done_inc;
  logic [31:0]         word_off;
  logic                rd_strb;
  logic                wr_strb;
  logic [31:0]         addr;

  assign nwords_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign words_done_inc = words_done + NWORDS_W'(1);
  // Byte offset of the current word; the 32-bit add wraps modulo 2^32.
  assign word_off       = {{OFF_PAD{1'b0}}, words_done, 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      nwords_q   <= '0;
      data_q     <= '0;
      words_done <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        nwords_q   <= nwords_clamped;
        words_done <= '0;
      end
      if (state == S_RD_LAT) begin
        data_q <= avm.avm_readdata;
      end
      if (state == S_WR && !avm.avm_waitrequest) begin
        words_done <= words_done_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rd_strb   = 1'b0;
    wr_strb   = 1'b0;
    addr      = '0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (nwords_clamped == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        rd_strb = 1'b1;
        addr    = src_q + word_off;
        if (!avm.avm_waitrequest) begin
          state_nxt = S_RD_LAT;
        end
      end
      S_RD_LAT: begin
        state_nxt = S_WR;
      end
      S_WR: begin
        wr_strb = 1'b1;
`ifdef STRING_HOST_DST_INC_EN
        addr    = dst_q + word_off;
`else
        addr    = dst_q;
`endif
        if (!avm.avm_waitrequest) begin
          state_nxt = (words_done_inc == nwords_q) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign avm.avm_address   = addr;
  assign avm.avm_read      = rd_strb;
  assign avm.avm_write     = wr_strb;
  assign avm.avm_writedata = data_q;

endmodule

// File: tb/tb_string_fifo_host.sv
// Bench for string_fifo_host: bus agent with synthetic memory, reference model of the expected transfer.
module tb_string_fifo_host;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [NW-1:0] num_words;
  logic          busy;
  logic          done;
  logic [NW-1:0] words_done;

  string_fifo_host_if bus();

  string_fifo_host #(.NWORDS_W(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .avm        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_mode;
  int rd_cnt, wr_cnt, rd_stall, wr_stall;
  int done_cnt, done_cyc, busy_cyc;
  bit rd_pend;
  logic [31:0] rd_pend_addr;
  bit prev_stalled;
  logic [31:0] prev_addr, prev_wdata;
  logic prev_rd, prev_wr;
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 3);
  endfunction

  task automatic clear_obs();
    rd_cnt = 0; wr_cnt = 0; rd_stall = 0; wr_stall = 0;
    done_cnt = 0; done_cyc = 0; busy_cyc = 0;
    rd_pend = 0; prev_stalled = 0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // One clock: observe outputs mid-cycle, act as the Avalon agent for the next edge.
  task automatic tick();
    logic w;
    @(negedge clk);
    cyc++;
    if (rd_pend) begin
      bus.avm_readdata = mem_word(rd_pend_addr);
      rd_pend = 0;
    end else begin
      bus.avm_readdata = $urandom;
    end
    if (prev_stalled) begin
      check("stall_addr", bus.avm_address, prev_addr);
      check("stall_read", bus.avm_read, prev_rd);
      check("stall_write", bus.avm_write, prev_wr);
      if (prev_wr) check("stall_wdata", bus.avm_writedata, prev_wdata);
    end
    check("rd_wr_excl", bus.avm_read & bus.avm_write, 1'b0);
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (busy === 1'b1) busy_cyc++;
    w = 1'b0;
    if (bus.avm_read === 1'b1) begin
      if (stall_mode == 1) w = ($urandom_range(0, 2) == 0);
      else if (stall_mode == 2 && rd_cnt == 1 && rd_stall < 4) begin w = 1'b1; rd_stall++; end
    end else if (bus.avm_write === 1'b1) begin
      if (stall_mode == 1) w = ($urandom_range(0, 2) == 0);
      else if (stall_mode == 2 && wr_cnt == 0 && wr_stall < 4) begin w = 1'b1; wr_stall++; end
    end
    bus.avm_waitrequest = w;
    prev_stalled = (bus.avm_read === 1'b1 || bus.avm_write === 1'b1) && w;
    prev_addr  = bus.avm_address;
    prev_wdata = bus.avm_writedata;
    prev_rd    = bus.avm_read;
    prev_wr    = bus.avm_write;
    if (bus.avm_read === 1'b1 && !w) begin
      rd_q.push_back(bus.avm_address);
      rd_pend = 1; rd_pend_addr = bus.avm_address; rd_cnt++;
    end
    if (bus.avm_write === 1'b1 && !w) begin
      wa_q.push_back(bus.avm_address);
      wd_q.push_back(bus.avm_writedata);
      wr_cnt++;
    end
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int mode, input int mid);
    int nc;
    int st;
    logic [31:0] ea;
    nc = (n > 16) ? 16 : n;
    clear_obs();
    stall_mode = mode;
    src_addr = s; dst_addr = d; num_words = NW'(n); start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      if (mid != 0 && i == mid) begin
        start = 1'b1; src_addr = ~s & ~32'h3; dst_addr = d + 32'h40; num_words = NW'(2);
      end
      tick();
      start = 1'b0;
    end
    check("done_seen", done_cnt, 1);
    if (mode == 0) begin
      check("done_latency", done_cyc - st, 3 * nc + 1);
      check("busy_len", busy_cyc, 3 * nc + 1);
    end
    if (mode == 2) begin
      check("rd_stall_len", rd_stall, 4);
      check("wr_stall_len", wr_stall, 4);
    end
    tick();
    check("busy_after", busy, 1'b0);
    check("words_done_final", words_done, nc);
    tick();
    check("done_once", done_cnt, 1);
    check("words_done_hold", words_done, nc);
    check("rd_count", rd_q.size(), nc);
    check("wr_count", wa_q.size(), nc);
    for (int i = 0; i < nc && i < rd_q.size() && i < wa_q.size(); i++) begin
      ea = s + 32'(4 * i);
      check($sformatf("rd_addr[%0d]", i), rd_q[i], ea);
      check($sformatf("wr_data[%0d]", i), wd_q[i], mem_word(ea));
`ifdef STRING_HOST_DST_INC_EN
      check($sformatf("wr_addr[%0d]", i), wa_q[i], d + 32'(4 * i));
`else
      check($sformatf("wr_addr[%0d]", i), wa_q[i], d);
`endif
    end
  endtask

  initial begin
    int hit;
    int wsz;
    reset = 1'b0; start = 1'b0;
    src_addr = '0; dst_addr = '0; num_words = '0;
    bus.avm_readdata = '0; bus.avm_waitrequest = 1'b0;
    stall_mode = 0;
    clear_obs();
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", bus.avm_read, 1'b0);
    check("rst_write", bus.avm_write, 1'b0);
    check("rst_addr", bus.avm_address, 32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    check("rst_words_done", words_done, '0);
    reset = 1'b1;
    tick();

    run_xfer(32'h0000_0100, 32'h8000_0000, 3, 0, 0);
    run_xfer(32'h0000_0400, 32'h0000_9000, 0, 0, 0);
    run_xfer(32'h0000_0200, 32'h0000_A000, 3, 2, 0);
    run_xfer(32'h0000_1000, 32'h0000_B000, 4, 0, 5);

    // Abort during the second word's write.
    clear_obs();
    stall_mode = 0;
    src_addr = 32'h2000; dst_addr = 32'h3000; num_words = NW'(4); start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.avm_write === 1'b1 && wa_q.size() == 2) begin hit = 1; break; end
    end
    check("rst_mid_reached", hit, 1);
    reset = 1'b0;
    tick();
    check("abort_read", bus.avm_read, 1'b0);
    check("abort_write", bus.avm_write, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_words_done", words_done, '0);
    wsz = wa_q.size();
    reset = 1'b1;
    repeat (6) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 1'b0);
    check("abort_no_resume", wa_q.size(), wsz);

    run_xfer(32'hFFFF_FFF8, 32'h0000_C000, 3, 0, 0);
    run_xfer(32'h0000_0040, 32'h0000_D000, 20, 0, 0);

    for (int k = 0; k < 8; k++) begin
      run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 20), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/string_fifo_host.md
STRING_FIFO_HOST -- requirements
Module: string_fifo_host

Interface
REQ-001 Parameter NWORDS_W, default 5, width of word-count ports; maximum transfer is 16 words.
REQ-002 clk  input  1  single system clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 src_addr  input  32  byte address of the first source word; must be word-aligned.
REQ-006 dst_addr  input  32  byte address of the accelerator FIFO data register (register 0).
REQ-007 num_words  input  NWORDS_W  number of 32-bit words to copy, 0..16.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-009 done  output  1  one-cycle pulse when the transfer completes.
REQ-010 words_done  output  NWORDS_W  count of words written so far in the current or last transfer.
REQ-011 avm_address  output  32  Avalon-MM host byte address.
REQ-012 avm_read / avm_write  output  1 each  Avalon-MM host read and write strobes; never both high in the same cycle.
REQ-013 avm_writedata  output  32  Avalon-MM host write data.
REQ-014 avm_readdata  input  32  Avalon-MM read data, valid exactly 1 cycle after read acceptance.
REQ-015 avm_waitrequest  input  1  agent stall; a command is accepted in a cycle where its strobe is high and waitrequest is low.

Function
REQ-016 States: IDLE, RD, RD_LAT, WR, DONE.
REQ-017 IDLE: on start=1, latch src_addr, dst_addr and num_words, clear words_done, then go to RD; if num_words=0, go to DONE instead.
REQ-018 RD: assert avm_read with avm_address = src_addr + 4*words_done; on acceptance, go to RD_LAT.
REQ-019 RD_LAT: capture avm_readdata into the data register (fixed 1-cycle latency, no bus strobes), then go to WR.
REQ-020 WR: assert avm_write with avm_address = dst_addr and avm_writedata = the captured word; on acceptance, increment words_done.
REQ-021 WR, after acceptance: if the new words_done equals the latched num_words, go to DONE; otherwise go to RD.
REQ-022 DONE: assert done for exactly one cycle, then go to IDLE; busy drops in the same cycle as the return to IDLE.
REQ-023 While avm_waitrequest=1, avm_address, avm_writedata and the active strobe hold their values unchanged.
REQ-024 start while busy is ignored, and the latched parameters are not disturbed.
REQ-025 Source-address arithmetic is modulo 2^32: wrap-around past 0xFFFFFFFC continues at 0x00000000.
REQ-026 num_words greater than 16 is clamped to 16.
REQ-027 words_done holds its final value in IDLE until the next accepted start.
REQ-028 Transfer throughput: 3 cycles per word with no waitrequest (RD, RD_LAT, WR).

Reset
REQ-029 With reset=0 at a rising edge: state=IDLE; busy, done, avm_read and avm_write = 0; avm_address, avm_writedata and words_done = 0.
REQ-030 Reset asserted mid-transfer aborts in that same edge; the partial transfer is not resumed and no done pulse is issued.

Configuration
REQ-031 Macro STRING_HOST_DST_INC_EN: when defined, the WR address is dst_addr + 4*words_done (memory-to-memory copy).
REQ-032 When STRING_HOST_DST_INC_EN is not defined, the WR address is always dst_addr (FIFO port); no extra adder is synthesized.

Verification
REQ-033 num_words=3, src=0x100, no stall -> reads at 0x100/0x104/0x108, 3 writes to dst_addr with matching data; done at cycle 10 after start; words_done=3.
REQ-034 num_words=0 -> no avm_read or avm_write; done pulses 1 cycle after start; busy high for 1 cycle.
REQ-035 waitrequest held high for 4 cycles on the 2nd read and on the 1st write -> address, data and strobes are stable throughout; data is still correct.
REQ-036 start pulsed in the middle of a 4-word transfer with different parameters -> ignored; the original 4 words complete.
REQ-037 reset=0 during WR of word 2 -> next cycle all strobes 0, state IDLE, words_done=0, no done.
REQ-038 src=0xFFFFFFF8, num_words=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; with STRING_HOST_DST_INC_EN defined, writes at dst, dst+4, dst+8.
